// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: data width, fetch FSM states and the canonical NOP.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. Supports push, pop and flush, and shows a zeroed head when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty     = (count == '0);
  assign do_push   = push & (count != FULL);
  assign do_pop    = pop & ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// RV32 instruction fetch stage. It issues credit-limited pipelined fetches and buffers the
// responses with their PCs. On a redirect it flushes the FIFO and drops any stale responses.
module fetch_prefetch_unit #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);
  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] fetch_pc, resp_pc, redir_pc_al;
  logic [CW-1:0]   outstanding, outstanding_next, drop_cnt, drop_cnt_next, fifo_count;
  logic            fifo_empty, req_fire, rsp_drop, fifo_push, fifo_pop;
  logic [2*XLEN-1:0] fifo_head;

  assign redir_pc_al    = {redirect_pc[XLEN-1:2], 2'b00};
  // Credit rule: FIFO slots plus in-flight requests never exceed DEPTH, so pushes never stall.
  assign imem_req_valid = (state != IDLE) & ~redirect_valid &
                          (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
  assign fifo_push      = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign fifo_pop       = instr_valid & instr_ready;

  assign instr_valid = ~fifo_empty;
  assign instr_pc    = fifo_head[2*XLEN-1:XLEN];
  assign instr_data  = fifo_head[XLEN-1:0];

  always_comb begin
    outstanding_next = outstanding;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  // Drops already pending are still counted in outstanding, so a redirect folds them in.
  always_comb begin
    drop_cnt_next = drop_cnt;
    if (redirect_valid) drop_cnt_next = outstanding - CW'(imem_rsp_valid);
    else if (rsp_drop)  drop_cnt_next = drop_cnt - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (redirect_valid && drop_cnt_next != '0) state_next = FLUSH;
      FLUSH:   if (drop_cnt_next == '0) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc <= redir_pc_al;
        resp_pc  <= redir_pc_al;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(4);
        if (fifo_push) resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_rsp_data}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  rsp_underflow: assert property (@(posedge clk) disable iff (reset)
                                  imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit. A transaction-level memory, FIFO and stream
// model drives randomized traffic and checks every cycle.
module tb_fetch_prefetch_unit;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr_data, instr_pc;

  logic        w_reset, w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready;
  logic [31:0] w_req_addr, w_rsp_data, w_instr_data, w_instr_pc;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
  );

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr_data(w_instr_data),
    .instr_pc(w_instr_pc)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        pend_q[$];
  ent_t        fifo_q[$];
  int unsigned drop, cyc, last_due, step_no, n_fire;
  int unsigned p_ready, p_iready, lat_min, lat_max;
  logic [31:0] exp_req, exp_pc, last_pop_pc, first_pop_pc;
  bit          run_en, last_rv, last_iv, last_pop, have_first;
  int          total = 0, bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    pend_q.delete(); fifo_q.delete();
    drop = 0; last_due = 0; step_no = 0; n_fire = 0;
    exp_req = 32'h0; exp_pc = 32'h0; run_en = 1'b0; have_first = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_data !== '0 || instr_pc !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req_valid=%b instr_valid=%b data=%h pc=%h, all required 0",
               imem_req_valid, instr_valid, instr_data, instr_pc);
    end
    reset = 1'b0;
  endtask

  // One cycle: drive inputs just after the falling edge, check, then advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt);
    req_t r;
    ent_t e;
    bit rspf, rfire, pop, exp_iv, exp_rv;
    int unsigned d;
    step_no++; cyc++;
    imem_req_ready = ($urandom_range(99) < p_ready);
    rspf = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    imem_rsp_valid = rspf;
    imem_rsp_data  = rspf ? mem_word(pend_q[0].addr) : $urandom;
    redirect_valid = redir;
    redirect_pc    = tgt;
    instr_ready    = ($urandom_range(99) < p_iready);
    #1;
    exp_iv = (fifo_q.size() != 0);
    total++;
    if (instr_valid !== exp_iv) begin
      bad++; $display("FAIL instr_valid @%0d: got %b want %b", cyc, instr_valid, exp_iv);
    end
    e.pc = '0; e.data = '0;
    if (exp_iv) e = fifo_q[0];
    total++;
    if (instr_pc !== e.pc || instr_data !== e.data) begin
      bad++; $display("FAIL head @%0d: got pc=%h data=%h want pc=%h data=%h",
                      cyc, instr_pc, instr_data, e.pc, e.data);
    end
    exp_rv = run_en && !redir && ((fifo_q.size() + pend_q.size()) < DEPTH);
    total++;
    if (imem_req_valid !== exp_rv) begin
      bad++; $display("FAIL req_valid @%0d: got %b want %b", cyc, imem_req_valid, exp_rv);
    end
    if (imem_req_valid === 1'b1) begin
      total++;
      if (imem_req_addr !== exp_req) begin
        bad++; $display("FAIL req_addr @%0d: got %h want %h", cyc, imem_req_addr, exp_req);
      end
    end
    rfire = (imem_req_valid === 1'b1) && imem_req_ready;
    pop   = (instr_valid === 1'b1) && instr_ready;
    last_rv = (imem_req_valid === 1'b1); last_iv = (instr_valid === 1'b1); last_pop = pop;
    if (pop) begin
      last_pop_pc = instr_pc;
      if (!have_first) begin have_first = 1'b1; first_pop_pc = instr_pc; end
      total++;
      if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
        bad++; $display("FAIL stream @%0d: got pc=%h data=%h want pc=%h data=%h",
                        cyc, instr_pc, instr_data, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (rspf) r = pend_q.pop_front();
    if (redir) begin
      fifo_q.delete();
      drop = pend_q.size();
      exp_req = {tgt[31:2], 2'b00};
      exp_pc  = exp_req;
    end else if (rspf) begin
      if (drop > 0) drop--;
      else fifo_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
    end
    if (rfire) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d < last_due) d = last_due;
      last_due = d;
      pend_q.push_back('{addr: imem_req_addr, due: d});
      exp_req = exp_req + 32'd4;
      n_fire++;
    end
    total++;
    if (pend_q.size() > DEPTH || fifo_q.size() > DEPTH) begin
      bad++; $display("FAIL bounds @%0d: outstanding=%0d count=%0d limit=%0d",
                      cyc, pend_q.size(), fifo_q.size(), DEPTH);
    end
    run_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int unsigned first_valid;
    p_ready = 100; p_iready = 100; lat_min = 1; lat_max = 1;
    do_reset();
    first_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0);
      if (last_iv && first_valid == 0) first_valid = i;
    end
    total++;
    if (first_valid != 4) begin
      bad++; $display("FAIL startup_latency: first instr_valid in cycle %0d, want 4", first_valid);
    end
    total++;
    if (!have_first || first_pop_pc !== 32'h0) begin
      bad++; $display("FAIL first_pc: got %h (seen=%b) want 00000000", first_pop_pc, have_first);
    end
  endtask

  task automatic test_stall();
    p_ready = 100; p_iready = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) step(1'b0, '0);
    total++;
    if (n_fire != 4 || last_rv || !last_iv) begin
      bad++; $display("FAIL stall_fill: requests=%0d req_valid=%b instr_valid=%b want 4,0,1",
                      n_fire, last_rv, last_iv);
    end
    p_iready = 100;
    step(1'b0, '0);
    p_iready = 0;
    step(1'b0, '0);
    total++;
    if (!last_rv) begin
      bad++; $display("FAIL stall_resume: req_valid=%b after pop, want 1", last_rv);
    end
  endtask

  task automatic test_redirect();
    p_ready = 100; p_iready = 100; lat_min = 6; lat_max = 6;
    do_reset();
    repeat (3) step(1'b0, '0);
    total++;
    if (n_fire != 2) begin
      bad++; $display("FAIL redir_setup: %0d requests in flight, want 2", n_fire);
    end
    step(1'b1, 32'h0000_0103);
    lat_min = 1; lat_max = 1; have_first = 1'b0;
    repeat (20) step(1'b0, '0);
    total++;
    if (!have_first || first_pop_pc !== 32'h100) begin
      bad++; $display("FAIL redir_target: first pc after redirect %h (seen=%b) want 00000100",
                      first_pop_pc, have_first);
    end
  endtask

  task automatic test_redirect_pop();
    bit ready_state;
    p_ready = 100; p_iready = 0; lat_min = 3; lat_max = 3;
    do_reset();
    ready_state = 1'b0;
    for (int i = 0; i < 20 && !ready_state; i++) begin
      step(1'b0, '0);
      ready_state = (fifo_q.size() >= 1) && (pend_q.size() >= 2) && (pend_q[0].due == cyc + 1);
    end
    total++;
    if (!ready_state) begin
      bad++; $display("FAIL redir_pop_setup: scenario not reached, fifo=%0d pend=%0d",
                      fifo_q.size(), pend_q.size());
    end
    p_iready = 100;
    step(1'b1, 32'h0000_0200);
    total++;
    if (!last_pop || last_pop_pc !== 32'h0) begin
      bad++; $display("FAIL redir_pop: pop=%b pc=%h want 1, 00000000", last_pop, last_pop_pc);
    end
    lat_min = 1; lat_max = 2; have_first = 1'b0;
    repeat (15) step(1'b0, '0);
    total++;
    if (!have_first || first_pop_pc !== 32'h200) begin
      bad++; $display("FAIL redir_pop_next: got %h (seen=%b) want 00000200", first_pop_pc, have_first);
    end
  endtask

  task automatic test_back_to_back();
    p_ready = 100; p_iready = 100; lat_min = 2; lat_max = 3;
    do_reset();
    repeat (6) step(1'b0, '0);
    step(1'b1, 32'h0000_1000);
    step(1'b1, 32'h0000_2002);
    have_first = 1'b0;
    repeat (15) step(1'b0, '0);
    total++;
    if (!have_first || first_pop_pc !== 32'h2000) begin
      bad++; $display("FAIL back_to_back: got %h (seen=%b) want 00002000", first_pop_pc, have_first);
    end
  endtask

  task automatic test_random();
    p_ready = 70; p_iready = 60; lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      step($urandom_range(99) < 4, $urandom);
    end
  endtask

  task automatic test_wrap();
    bit          pf;
    logic [31:0] pa, exp;
    int unsigned got;
    w_reset = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0; w_instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    w_reset = 1'b0;
    pf = 1'b0; pa = '0; exp = 32'hFFFF_FFF8; got = 0;
    for (int i = 0; i < 20; i++) begin
      w_rsp_valid = pf;
      w_rsp_data  = mem_word(pa);
      #1;
      if (w_instr_valid === 1'b1) begin
        total++;
        if (w_instr_pc !== exp || w_instr_data !== mem_word(exp)) begin
          bad++; $display("FAIL wrap_stream: got pc=%h data=%h want pc=%h data=%h",
                          w_instr_pc, w_instr_data, exp, mem_word(exp));
        end
        exp = exp + 32'd4;
        got++;
      end
      pf = (w_req_valid === 1'b1);
      pa = w_req_addr;
      @(negedge clk);
    end
    total++;
    if (got < 3) begin
      bad++; $display("FAIL wrap_count: %0d instructions delivered, want at least 3", got);
    end
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1; cyc = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
